// File: rtl/array_west_feeder_pkg.sv
// Shared definitions for the west-edge feeder: inst encodings, FSM states
// and default array geometry.
package array_west_feeder_pkg;

    localparam logic [1:0] INST_IDLE = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

    localparam int DEF_BW     = 4;
    localparam int DEF_ROW    = 8;
    localparam int DEF_COL    = 8;
    localparam int DEF_CNT_BW = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EXEC,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/array_west_feeder_skew_pipe.sv
// Fixed-depth shift register with asynchronous clear; one per array row
// to produce the diagonal wavefront.
module skew_pipe #(
    parameter int depth = 1,
    parameter int width = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [depth-1:0][width-1:0] stages;

    generate
        if (depth == 1) begin : g_single
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    stages <= '0;
                end else begin
                    stages[0] <= d;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    stages <= '0;
                end else begin
                    stages <= {stages[depth-2:0], d};
                end
            end
        end
    endgenerate

    assign q = stages[depth-1];

endmodule

// File: rtl/array_west_feeder.sv
// West-edge transmitter: streams a kernel load followed by execute vectors
// from L0 into the MAC array, skewing row r by r cycles.
module array_west_feeder
    import array_west_feeder_pkg::*;
#(
    parameter int bw     = DEF_BW,
    parameter int row    = DEF_ROW,
    parameter int col    = DEF_COL,
    parameter int cnt_bw = DEF_CNT_BW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [cnt_bw-1:0]   num_exec,
    input  logic [row*bw-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [row*bw-1:0]   out_w,
    output logic [2*row-1:0]    inst_w,
    output logic                busy,
    output logic                done
);

    localparam int LOAD_W  = (col > 1) ? $clog2(col) : 1;
    localparam int DRAIN_W = (row > 2) ? $clog2(row - 1) : 1;

    localparam logic [LOAD_W-1:0]  LOAD_LAST  = LOAD_W'(col - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((row > 1) ? row - 2 : 0);

    // A single-row array has nothing to drain, so the run ends straight in DONE.
    localparam state_t RUN_END = (row > 1) ? DRAIN : DONE;

    state_t state, next_state;

    logic [LOAD_W-1:0]  load_cnt;
    logic [cnt_bw-1:0]  exec_cnt;
    logic [cnt_bw-1:0]  num_exec_q;
    logic [DRAIN_W-1:0] drain_cnt;

    logic       transfer;
    logic       load_last;
    logic       exec_last;
    logic [1:0] slot_inst;

    assign transfer  = in_valid && in_ready;
    assign load_last = transfer && (state == LOAD) && (load_cnt == LOAD_LAST);
    assign exec_last = transfer && (state == EXEC) &&
                       (exec_cnt == num_exec_q - cnt_bw'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    if (load_last) next_state = (num_exec_q == '0) ? RUN_END : EXEC;
            EXEC:    if (exec_last) next_state = RUN_END;
            DRAIN:   if (drain_cnt == DRAIN_LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        slot_inst = INST_IDLE;
        case (state)
            LOAD: begin
                in_ready  = 1'b1;
                busy      = 1'b1;
                slot_inst = INST_LOAD;
            end
            EXEC: begin
                in_ready  = 1'b1;
                busy      = 1'b1;
                slot_inst = INST_EXEC;
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Counters restart in IDLE; num_exec is captured only on an accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_cnt   <= '0;
            exec_cnt   <= '0;
            drain_cnt  <= '0;
            num_exec_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    load_cnt  <= '0;
                    exec_cnt  <= '0;
                    drain_cnt <= '0;
                    if (start) num_exec_q <= num_exec;
                end
                LOAD:    if (transfer) load_cnt <= load_cnt + LOAD_W'(1);
                EXEC:    if (transfer) exec_cnt <= exec_cnt + cnt_bw'(1);
                DRAIN:   drain_cnt <= drain_cnt + DRAIN_W'(1);
                default: ;
            endcase
        end
    end

    // Bubbles enter the pipes as all-zero slots so every row sees the same sequence.
    generate
        for (genvar r = 0; r < row; r++) begin : g_lane
            logic [bw+1:0] slot_d;
            logic [bw+1:0] slot_q;

            assign slot_d = transfer ? {slot_inst, in_data[r*bw +: bw]} : '0;

            skew_pipe #(
                .depth (r + 1),
                .width (bw + 2)
            ) u_skew (
                .clk   (clk),
                .reset (reset),
                .d     (slot_d),
                .q     (slot_q)
            );

            assign out_w[r*bw +: bw] = slot_q[bw-1:0];
            assign inst_w[2*r +: 2]  = slot_q[bw +: 2];
        end
    endgenerate

endmodule
